// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int              BCD_DIGIT_W    = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] BCD_NINE       = 4'd9;

endpackage

// File: rtl/bcd_digit_step.sv
// One double-dabble digit slice: add-3 adjust, then shift left taking shift_in
// as the new LSB; the adjusted MSB leaves as carry into the next digit.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    input  logic                   shift_in,
    output logic [BCD_DIGIT_W-1:0] digit_next,
    output logic                   carry
);

    logic [BCD_DIGIT_W-1:0] adj;

    always_comb begin
        adj        = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;
        digit_next = {adj[BCD_DIGIT_W-2:0], shift_in};
        carry      = adj[BCD_DIGIT_W-1];
    end

endmodule

// File: rtl/bcd_seq_conv_ctrl.sv
// Handshaked bit-serial binary-to-BCD converter (one input bit per clock).
// Optional leading-zero blanking output is enabled with macro BCD_LZB_EN.
module bcd_seq_conv_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_bin,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   out_bcd,
    output logic                            out_ovf,
    output logic                            busy
`ifdef BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]               out_blank
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = BCD_DIGIT_W * DIGITS;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid, once raised, holds its data stable until that edge.

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q;
    logic [BW-1:0]     dig_q, dig_next, sat_bcd;
    logic [DIGITS:0]   chain;
    logic              ovf_q, ovf_next, last;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     res_bcd_q;
    logic              res_ovf_q;

    assign chain[0] = sr_q[WIDTH-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (dig_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .shift_in   (chain[g]),
            .digit_next (dig_next[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .carry      (chain[g+1])
        );
    end

    assign ovf_next = ovf_q | chain[DIGITS];
    assign last     = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    assign sat_bcd  = ovf_next ? {DIGITS{BCD_NINE}} : dig_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BCD_LZB_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              upper_zero;

    // Scan from the top digit down; bit 0 never blanks so a zero still shows.
    always_comb begin
        blank_d    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (dig_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_d[i] = upper_zero & ~ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (state_q == IDLE && in_valid) begin
            blank_q <= '0;
        end else if (last) begin
            blank_q <= blank_d;
        end
    end

    assign out_blank = blank_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            dig_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            res_bcd_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q      <= in_bin;
                        dig_q     <= '0;
                        ovf_q     <= 1'b0;
                        cnt_q     <= '0;
                        res_bcd_q <= '0;
                        res_ovf_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
                    dig_q <= dig_next;
                    ovf_q <= ovf_next;
                    cnt_q <= cnt_q + CW'(1);
                    // Result registers load once, so they stay frozen through DONE.
                    if (last) begin
                        res_bcd_q <= sat_bcd;
                        res_ovf_q <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_bcd = res_bcd_q;
    assign out_ovf = res_ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv_ctrl.sv
// Self-checking bench: a 4-digit and a 3-digit converter share one stimulus
// stream and are compared against an arithmetic decimal reference model.
module tb_bcd_seq_conv_ctrl;

    localparam int WIDTH = 12;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_bin;
    logic        out_ready;

    logic        in_ready4, out_valid4, out_ovf4, busy4;
    logic [15:0] out_bcd4;
    logic        in_ready3, out_valid3, out_ovf3, busy3;
    logic [11:0] out_bcd3;
`ifdef BCD_LZB_EN
    logic [3:0]  out_blank4;
    logic [2:0]  out_blank3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bcd_seq_conv_ctrl #(.WIDTH(WIDTH), .DIGITS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_bin    (in_bin),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_bcd   (out_bcd4),
        .out_ovf   (out_ovf4),
        .busy      (busy4)
`ifdef BCD_LZB_EN
        ,
        .out_blank (out_blank4)
`endif
    );

    bcd_seq_conv_ctrl #(.WIDTH(WIDTH), .DIGITS(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .in_bin    (in_bin),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_bcd   (out_bcd3),
        .out_ovf   (out_ovf3),
        .busy      (busy3)
`ifdef BCD_LZB_EN
        ,
        .out_blank (out_blank3)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain decimal arithmetic
    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v, input int nd);
        logic [15:0] r = '0;
        int          x = v;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = (v >= pow10(nd)) ? 4'd9 : 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int nd);
        return v >= pow10(nd);
    endfunction

    function automatic logic [3:0] ref_blank(input int v, input int nd);
        logic [3:0] b = '0;
        if (v < pow10(nd))
            for (int i = 1; i < nd; i++) b[i] = (v < pow10(i));
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_result(input int v);
        chk("bcd4", 32'(out_bcd4), 32'(ref_bcd(v, 4)));
        chk("ovf4", 32'(out_ovf4), 32'(ref_ovf(v, 4)));
        chk("bcd3", 32'(out_bcd3), 32'(ref_bcd(v, 3)));
        chk("ovf3", 32'(out_ovf3), 32'(ref_ovf(v, 3)));
`ifdef BCD_LZB_EN
        chk("blank4", 32'(out_blank4), 32'(ref_blank(v, 4)));
        chk("blank3", 32'(out_blank3), 32'(ref_blank(v, 3) & 4'b0111));
`endif
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_in_ready"},  32'({in_ready4, in_ready3}),   32'b11);
        chk({tag, "_out_valid"}, 32'({out_valid4, out_valid3}), 32'b00);
        chk({tag, "_busy"},      32'({busy4, busy3}),           32'b00);
        chk({tag, "_bcd"},       32'({out_bcd4, out_bcd3}),     32'd0);
        chk({tag, "_ovf"},       32'({out_ovf4, out_ovf3}),     32'b00);
`ifdef BCD_LZB_EN
        chk({tag, "_blank"},     32'({out_blank4, out_blank3}), 32'd0);
`endif
    endtask

    // Driver: called at a negedge with the DUTs idle. The accept edge ends
    // cycle 0; out_valid must be seen in cycle WIDTH+1, i.e. WIDTH edges later.
    task automatic run_conv(input int v, input int stall, input bit hold_valid);
        int lat;
        chk("pre_in_ready", 32'(in_ready4), 32'd1);
        in_bin    = 12'(v);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        chk("accept_busy", 32'({busy4, busy3, in_ready4}), 32'b110);
        in_valid = hold_valid;
        in_bin   = 12'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(WIDTH));
        chk("valid3", 32'(out_valid3), 32'd1);
        chk_result(v);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_hold", 32'({out_valid4, in_ready4, busy4}), 32'b101);
            chk_result(v);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_idle", 32'({out_valid4, in_ready4, busy4, in_ready3}), 32'b0101);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_conv(255, 0, 1'b0);
        // in_valid held: next accept must land one cycle after the handshake
        run_conv(4095, 0, 1'b1);
        run_conv(0, 0, 1'b0);
        run_conv(1234, 6, 1'b0);
        run_conv(1000, 1, 1'b0);
        run_conv(999, 0, 1'b0);
        run_conv(7, 2, 1'b0);

        // Abort in the middle of a conversion
        in_bin   = 12'd777;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_reset("after_rst");
        run_conv(42, 0, 1'b0);

        for (int k = 0; k < 30; k++)
            run_conv(int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
